// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: control and output bundle for the clk_div_gen clock divider.
// The master side (the consumer of the divided clock) drives the run request,
// the divisor and the burst length. The slave side (the divider) returns the
// divided clock, the edge strobes and the status flags.
interface clk_div_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic             enable;
  logic [DIV_W-1:0] divisor;
  logic [CNT_W-1:0] burstLen;
  logic             outClk;
  logic             riseEn;
  logic             fallEn;
  logic             busy;
  logic             done;

  modport master (
    output enable, divisor, burstLen,
    input  outClk, riseEn, fallEn, busy, done
  );

  modport slave (
    input  enable, divisor, burstLen,
    output outClk, riseEn, fallEn, busy, done
  );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable clock divider and clock-enable generator.
// Divides refClk by max(divisor, 2). It emits a registered divided clock and
// single-cycle rise/fall strobes, so downstream logic can stay in the refClk
// domain. The divisor is only re-sampled at period boundaries, and a stop
// request always completes the current period, so no runt pulses occur.
// Optional feature macro: CLKDIV_BURST_EN. When it is defined, a nonzero
// burstLen stops the output after that many periods, pulses done and holds
// until enable drops. When it is undefined, burstLen is ignored and done is 0.
module clk_div_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic         refClk,
  input  logic         rstN,
  clk_div_gen_if.slave bus
);

`ifdef CLKDIV_BURST_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             out_clk_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] high_phase;
  logic [DIV_W-1:0] cnt_inc;
  logic             period_last;

  // Divisors 0 and 1 cannot form a high and a low phase, so they run as 2.
  assign div_clamped = (bus.divisor < DIV_W'(2)) ? DIV_W'(2) : bus.divisor;
  // The high phase takes the extra cycle of an odd divisor: H = ceil(D/2).
  assign high_phase  = div_q - (div_q >> 1);
  assign cnt_inc     = cnt_q + DIV_W'(1);
  assign period_last = (cnt_q == div_q - DIV_W'(1));

`ifdef CLKDIV_BURST_EN
  logic [CNT_W-1:0] burst_len_q;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_inc;
  logic             burst_last;
  logic             done_q;

  // The completed-period count saturates so that it can never wrap back
  // and retrigger a burst end.
  assign burst_cnt_inc = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
  assign burst_last    = (burst_len_q != '0) && (burst_cnt_inc == burst_len_q);
  assign bus.done      = done_q;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^bus.burstLen;
  assign bus.done         = 1'b0;
`endif

  assign bus.outClk = out_clk_q;
  assign bus.riseEn = rise_q;
  assign bus.fallEn = fall_q;
  assign bus.busy   = busy_q;

  // Control FSM. Each output register is loaded with the value that belongs
  // to the count being entered, so the outputs line up with cnt_q.
  always_ff @(posedge refClk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(2);
      out_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CLKDIV_BURST_EN
      burst_len_q <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments let every register here sample the
      // pre-edge values, whatever order the statements appear in.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`ifdef CLKDIV_BURST_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            state_q   <= S_RUN;
            div_q     <= div_clamped;
            cnt_q     <= '0;
            out_clk_q <= 1'b1;
            rise_q    <= 1'b1;
            busy_q    <= 1'b1;
`ifdef CLKDIV_BURST_EN
            burst_len_q <= bus.burstLen;
            burst_cnt_q <= '0;
`endif
          end
        end
        S_RUN: begin
          if (period_last) begin
`ifdef CLKDIV_BURST_EN
            burst_cnt_q <= burst_cnt_inc;
`endif
            cnt_q <= '0;
            if (!bus.enable) begin
              state_q   <= S_IDLE;
              out_clk_q <= 1'b0;
              busy_q    <= 1'b0;
`ifdef CLKDIV_BURST_EN
            end else if (burst_last) begin
              state_q   <= S_HOLD;
              out_clk_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
`endif
            end else begin
              div_q     <= div_clamped;
              out_clk_q <= 1'b1;
              rise_q    <= 1'b1;
            end
          end else begin
            cnt_q     <= cnt_inc;
            out_clk_q <= (cnt_inc < high_phase);
            fall_q    <= (cnt_inc == high_phase);
          end
        end
`ifdef CLKDIV_BURST_EN
        S_HOLD: begin
          if (!bus.enable) state_q <= S_IDLE;
        end
`endif
        default: begin
          state_q   <= S_IDLE;
          out_clk_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: table-driven bench for clk_div_gen. Each table row gives the
// inputs applied before one refClk edge and the {outClk, riseEn, fallEn, busy,
// done} expected after that edge. Hand-written sequences cover the reset
// corners. Works with and without CLKDIV_BURST_EN.
module tb_clk_div_gen;

  typedef struct {
    logic       en;
    logic [7:0] div;
    logic [7:0] blen;
    logic [4:0] exp;   // {outClk, riseEn, fallEn, busy, done}
  } vec_t;

  logic refClk = 1'b0;
  logic rstN   = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  vec_t vecs[$];
  int   s1_len;

  clk_div_gen_if #(.DIV_W(8), .CNT_W(8)) bus ();

  clk_div_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .refClk (refClk),
    .rstN   (rstN),
    .bus    (bus)
  );

  always #5 refClk = ~refClk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {out,rise,fall,busy,done}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.outClk, bus.riseEn, bus.fallEn, bus.busy, bus.done};
  endfunction

  task automatic add_row(input logic en, input logic [7:0] div, input logic [7:0] blen,
                         input logic [4:0] exp);
    vec_t v;
    v.en = en; v.div = div; v.blen = blen; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One full running period: h high cycles (the first carries riseEn) and
  // l low cycles (the first carries fallEn), busy high throughout.
  task automatic add_period(input logic en, input logic [7:0] div, input int h,
                            input int l, input logic [7:0] blen);
    for (int i = 0; i < h; i++) add_row(en, div, blen, (i == 0) ? 5'b11010 : 5'b10010);
    for (int i = 0; i < l; i++) add_row(en, div, blen, (i == 0) ? 5'b00110 : 5'b00010);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_row(1'b0, 8'd5, 8'd0, 5'b00000);
  endtask

  task automatic apply_rows(input int first, input int last);
    for (int i = first; i < last; i++) begin
      bus.enable   = vecs[i].en;
      bus.divisor  = vecs[i].div;
      bus.burstLen = vecs[i].blen;
      @(posedge refClk);
      #1;
      check($sformatf("row%0d", i), outs(), vecs[i].exp);
    end
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.divisor  = 8'd5;
    bus.burstLen = 8'd0;

    // Scenario 1: divisor 5, 3 high / 2 low, stopped at a boundary.
    for (int p = 0; p < 3; p++) add_period(1'b1, 8'd5, 3, 2, 8'd0);
    add_idle(1);
    s1_len = vecs.size();

    // Scenario 2: divisor 4 changed to 6 while cnt = 1.
    add_period(1'b1, 8'd4, 2, 2, 8'd0);
    vecs[vecs.size()-2].div = 8'd6;
    vecs[vecs.size()-1].div = 8'd6;
    for (int p = 0; p < 2; p++) add_period(1'b1, 8'd6, 3, 3, 8'd0);
    add_idle(1);

    // Scenario 3: divisors 0 and 1 behave as 2.
    for (int p = 0; p < 3; p++) add_period(1'b1, 8'd0, 1, 1, 8'd0);
    add_idle(1);
    for (int p = 0; p < 3; p++) add_period(1'b1, 8'd1, 1, 1, 8'd0);
    add_idle(1);

    // Scenario 4: divisor 8, enable dropped while cnt = 2; the period completes.
    add_period(1'b1, 8'd8, 4, 4, 8'd0);
    for (int i = vecs.size() - 5; i < vecs.size(); i++) vecs[i].en = 1'b0;
    add_idle(2);

    // Scenario 5: burstLen 3 with divisor 4 and enable held high.
`ifdef CLKDIV_BURST_EN
    for (int p = 0; p < 3; p++) add_period(1'b1, 8'd4, 2, 2, 8'd3);
    add_row(1'b1, 8'd4, 8'd3, 5'b00001);
    for (int i = 0; i < 3; i++) add_row(1'b1, 8'd4, 8'd3, 5'b00000);
    add_row(1'b0, 8'd4, 8'd3, 5'b00000);
    add_period(1'b1, 8'd4, 2, 2, 8'd3);
    add_idle(1);
`else
    for (int p = 0; p < 4; p++) add_period(1'b1, 8'd4, 2, 2, 8'd3);
    add_idle(1);
`endif

    // Reset state, before any clocking out of reset.
    #12;
    check("reset_state", outs(), 5'b00000);
    rstN = 1'b1;

    apply_rows(0, vecs.size());

    // Asynchronous reset while outClk is high, mid-period (and mid-burst).
    bus.enable   = 1'b1;
    bus.divisor  = 8'd5;
    bus.burstLen = 8'd3;
    @(posedge refClk);
    #1;
    check("pre_reset_start", outs(), 5'b11010);
    @(posedge refClk);
    #1;
    check("pre_reset_cnt1", outs(), 5'b10010);
    #2;
    rstN = 1'b0;
    #1;
    check("async_reset_clear", outs(), 5'b00000);
    bus.enable = 1'b0;
    @(posedge refClk);
    #1;
    check("reset_held", outs(), 5'b00000);
    #3;
    rstN = 1'b1;

    // After release, a restart matches the first scenario.
    apply_rows(0, s1_len);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
